pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
Output-side counterpart of the input debouncer. It takes single-cycle request pulses from internal logic and drives a clean level to a physical output such as an LED, buzzer or strobe line. Each request produces exactly HIGH_CYCLES cycles high, followed by a guaranteed GAP_CYCLES cycles low. Requests that arrive while busy are queued in a saturating counter and replayed in order.

Parameters:
HIGH_CYCLES, 8, output-high duration per request in clock cycles; must be 1..2^CNT_W
GAP_CYCLES, 4, minimum low time after each high phase in clock cycles; must be 1..2^CNT_W
CNT_W, 8, width of the internal duration timer
PEND_W, 2, width of the pending-request counter; the queue saturates at 2^PEND_W-1

Ports:
Clk  input  1  system clock; all state updates on its rising edge
Reset  input  1  synchronous active-low reset; sampled on the Clk rising edge
pulseInput  input  1  request; each cycle it is high counts as one request
signalOutput  output  1  stretched output level, registered
busy  output  1  high whenever state is not IDLE, registered
pendingCount  output  PEND_W  number of queued requests, registered
overflow  output  1  one-cycle pulse when a request is dropped because the queue is full

Behaviour:
- Timing convention: "input in cycle n" means the signal is sampled at the edge that ends cycle n. Registered outputs change in cycle n+1.
- Reset==0 at an edge: state goes to IDLE; signalOutput, busy, overflow, pendingCount and the timer all go to 0.
  - pulseInput is ignored while Reset==0.
  - Reset applied mid-ACTIVE or mid-GAP discards the current phase and all queued requests.
- States: IDLE, ACTIVE, GAP. Internal timer is a CNT_W-bit down-counter.
- IDLE:
  - pulseInput=1 in cycle n: go to ACTIVE and load the timer with HIGH_CYCLES-1. signalOutput is high from cycle n+1 (latency 1).
  - Otherwise stay in IDLE.
- ACTIVE:
  - signalOutput=1.
  - If timer!=0: decrement it.
  - If timer==0: go to GAP, load GAP_CYCLES-1; signalOutput drops to 0 in the next cycle.
  - Result: exactly HIGH_CYCLES high cycles per request.
- GAP:
  - signalOutput=0.
  - If timer!=0: decrement it.
  - If timer==0 and a request is available (pendingCount>0 or pulseInput=1 this cycle): go to ACTIVE, load HIGH_CYCLES-1, consume one request.
  - If timer==0 and no request is available: go to IDLE.
  - Result: exactly GAP_CYCLES low cycles between consecutive high phases, with no extra idle cycle.
- Queueing (pulseInput=1 while in ACTIVE or GAP, excluding the consuming GAP-end cycle):
  - If pendingCount < 2^PEND_W-1: pendingCount increments.
  - Else: pendingCount holds and overflow=1 for exactly one cycle (next cycle).
- Simultaneous events at GAP end:
  - pendingCount=0 and pulseInput=1: the new request is consumed directly; pendingCount stays 0.
  - pendingCount>0 and pulseInput=1: one request is consumed and one is enqueued; pendingCount is unchanged and overflow stays 0.
  - pendingCount>0 and pulseInput=0: pendingCount decrements.
- Outputs:
  - busy=1 in ACTIVE and GAP, 0 in IDLE; it updates on the same edge as the state.
  - overflow is 0 in every cycle not described above.
- A level held high on pulseInput for k cycles counts as k requests. Callers drive single-cycle pulses, e.g. from the debouncer output.

Test Plan:
(All scenarios use defaults HIGH_CYCLES=8, GAP_CYCLES=4, PEND_W=2.)
1. Reset=0 for 3 cycles with pulseInput=1 throughout, then release -> all outputs 0 and state IDLE; no output pulse follows.
2. Single pulse in cycle 10 -> signalOutput high in cycles 11-18, low from 19; busy high in 11-22, back to 0 in 23; pendingCount stays 0.
3. Pulses in cycles 10 and 12 -> first high phase 11-18; pendingCount=1 in 13-22; gap 19-22; second high phase 23-30; busy drops in 35.
4. Pulses in cycles 10-14 (5 consecutive) -> pendingCount reaches 1, 2, 3 in cycles 12-14; overflow=1 in cycle 15 only; exactly 4 high phases, starting in cycles 11, 23, 35 and 47.
5. Single pulse in cycle 10, then another in cycle 22 (last GAP cycle, queue empty) -> second high phase 23-30 with no IDLE cycle between; pendingCount stays 0.
6. Pulses in cycles 10, 11 and 12, then Reset=0 in cycle 14 -> from cycle 15: signalOutput=0, busy=0, pendingCount=0; after release, no queued pulse replays.

Source files
------------

// File: rtl/pulse_stretcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher_if
//  Description : Request/level bundle between a pulse source and the pulse
//                stretcher. The master raises requests and observes status.
//                The slave is the stretcher and drives the output level.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pulse_stretcher_if #(
   parameter int PEND_W = 2
);
   logic              pulseInput;
   logic              signalOutput;
   logic              busy;
   logic [PEND_W-1:0] pendingCount;
   logic              overflow;

   modport master (
      output pulseInput,
      input  signalOutput,
      input  busy,
      input  pendingCount,
      input  overflow
   );

   modport slave (
      input  pulseInput,
      output signalOutput,
      output busy,
      output pendingCount,
      output overflow
   );
endinterface
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Turns single-cycle request pulses into a clean output level.
//                Each request gives HIGH_CYCLES high cycles, then at least
//                GAP_CYCLES low cycles. Requests that arrive while busy are
//                held in a saturating counter and replayed in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
   parameter int HIGH_CYCLES = 8,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8,
   parameter int PEND_W      = 2
) (
   input  wire logic          Clk,
   input  wire logic          Reset,
   pulse_stretcher_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   // Timer reload values. The timer counts down to zero, so each phase
   // lasts (load + 1) cycles.
   localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic [PEND_W-1:0] pend_q,  pend_d;
   logic              ovf_q,   ovf_d;
   logic              sig_q,   sig_d;
   logic              busy_q,  busy_d;

   // Set when the current request has to be queued, not started now.
   logic              enqueue;
   logic              timer_zero;
   logic              pend_nonzero;

   assign timer_zero   = (timer_q == '0);
   assign pend_nonzero = (pend_q != '0);

   // Next-state, timer and queue logic.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;
      enqueue = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.pulseInput) begin
               state_d = ACTIVE;
               timer_d = HIGH_LOAD;
            end
         end

         ACTIVE: begin
            enqueue = bus.pulseInput;
            if (!timer_zero) begin
               timer_d = timer_q - CNT_ONE;
            end else begin
               state_d = GAP;
               timer_d = GAP_LOAD;
            end
         end

         GAP: begin
            if (!timer_zero) begin
               timer_d = timer_q - CNT_ONE;
               enqueue = bus.pulseInput;
            end else if (pend_nonzero || bus.pulseInput) begin
               // Back-to-back start: one request is consumed here. A new
               // request arriving now replaces the consumed one, so the
               // count only drops when nothing arrives.
               state_d = ACTIVE;
               timer_d = HIGH_LOAD;
               if (pend_nonzero && !bus.pulseInput) begin
                  pend_d = pend_q - PEND_ONE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
            pend_d  = '0;
         end
      endcase

      // Saturating queue: a request that finds the queue full is dropped
      // and flagged for one cycle.
      if (enqueue) begin
         if (pend_q != PEND_MAX) begin
            pend_d = pend_q + PEND_ONE;
         end else begin
            ovf_d = 1'b1;
         end
      end

      sig_d  = (state_d == ACTIVE);
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         sig_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         sig_q   <= sig_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.signalOutput = sig_q;
   assign bus.busy         = busy_q;
   assign bus.pendingCount = pend_q;
   assign bus.overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Self-checking bench for pulse_stretcher. Directed table,
//                hand-written corner sequences and random stimulus, all
//                compared against a schedule-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

   localparam int HIGH_CYCLES = 8;
   localparam int GAP_CYCLES  = 4;
   localparam int CNT_W       = 8;
   localparam int PEND_W      = 2;
   localparam int PEND_MAXI   = (1 << PEND_W) - 1;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   pulse_stretcher_if #(.PEND_W(PEND_W)) bus ();

   pulse_stretcher #(
      .HIGH_CYCLES (HIGH_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .CNT_W       (CNT_W),
      .PEND_W      (PEND_W)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Reference model: every accepted request is given the cycle its high
   // phase starts. A phase starts one cycle after the request or right
   // after the previous phase's high+gap window, whichever is later.
   typedef struct {
      int req;
      int start;
   } acc_t;

   acc_t acc[$];
   int   last_start = -1000;
   int   drop_cyc   = -10;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic void model_update(input int n, input bit r, input bit p);
      int cand;
      int still_pending;
      if (!r) begin
         acc.delete();
         last_start = -1000;
         drop_cyc   = -10;
      end else if (p) begin
         cand = (n + 1 > last_start + HIGH_CYCLES + GAP_CYCLES) ?
                n + 1 : last_start + HIGH_CYCLES + GAP_CYCLES;
         still_pending = 0;
         foreach (acc[i]) if (acc[i].start > n + 1) still_pending++;
         if (still_pending >= PEND_MAXI) begin
            drop_cyc = n;
         end else begin
            acc.push_back('{req: n, start: cand});
            last_start = cand;
         end
      end
      while (acc.size() > 0 && acc[0].start + HIGH_CYCLES + GAP_CYCLES <= n)
         void'(acc.pop_front());
   endfunction

   function automatic void model_exp(input int c, output logic es, output logic eb,
                                     output logic [PEND_W-1:0] ep, output logic eo);
      int cnt;
      cnt = 0;
      es  = 1'b0;
      eb  = 1'b0;
      eo  = (drop_cyc == c - 1);
      foreach (acc[i]) begin
         if (acc[i].start <= c && c < acc[i].start + HIGH_CYCLES) es = 1'b1;
         if (acc[i].start <= c && c < acc[i].start + HIGH_CYCLES + GAP_CYCLES) eb = 1'b1;
         if (acc[i].req < c && acc[i].start > c) cnt++;
      end
      ep = PEND_W'(cnt);
   endfunction

   // Drive one cycle of inputs (called at a falling edge), let the rising
   // edge sample them, then compare outputs against the model mid-cycle.
   task automatic step(input bit r, input bit p);
      logic es, eb, eo;
      logic [PEND_W-1:0] ep;
      Reset = r;
      bus.pulseInput = p;
      @(posedge Clk);
      model_update(cyc, r, p);
      if (!r) chk_en = 1'b1;
      cyc++;
      @(negedge Clk);
      if (chk_en) begin
         model_exp(cyc, es, eb, ep, eo);
         check("model_sig",  {31'd0, bus.signalOutput}, {31'd0, es});
         check("model_busy", {31'd0, bus.busy},         {31'd0, eb});
         check("model_pend", 32'(bus.pendingCount),     32'(ep));
         check("model_ovf",  {31'd0, bus.overflow},     {31'd0, eo});
      end
   endtask

   task automatic reset_seq();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   typedef struct {
      logic              pulse;
      logic              sig;
      logic              busy;
      logic [PEND_W-1:0] pend;
      logic              ovf;
   } vec_t;

   vec_t tab [0:63];

   initial begin
      bit p;
      bit r;

      // Five back-to-back requests in cycles 10..14: queue fills, the fifth
      // overflows, four high phases follow at a 12-cycle pitch.
      for (int t = 0; t < 64; t++) begin
         tab[t].pulse = (t >= 10 && t <= 14);
         tab[t].sig   = (t >= 11 && t <= 18) || (t >= 23 && t <= 30) ||
                        (t >= 35 && t <= 42) || (t >= 47 && t <= 54);
         tab[t].busy  = (t >= 11 && t <= 58);
         tab[t].pend  = (t == 12) ? 2'd1 : (t == 13) ? 2'd2 :
                        (t >= 14 && t <= 22) ? 2'd3 :
                        (t >= 23 && t <= 34) ? 2'd2 :
                        (t >= 35 && t <= 46) ? 2'd1 : 2'd0;
         tab[t].ovf   = (t == 15);
      end

      bus.pulseInput = 1'b0;
      @(negedge Clk);

      // Reset held for 3 cycles with the request line high throughout.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      check("rst_sig",  {31'd0, bus.signalOutput}, 32'd0);
      check("rst_busy", {31'd0, bus.busy},         32'd0);
      check("rst_pend", 32'(bus.pendingCount),     32'd0);
      check("rst_ovf",  {31'd0, bus.overflow},     32'd0);
      for (int t = 0; t < 20; t++) step(1'b1, 1'b0);
      check("rst_no_pulse", {31'd0, bus.signalOutput}, 32'd0);

      // Table: queue saturation and overflow.
      reset_seq();
      for (int t = 0; t < 64; t++) begin
         check("tab_sig",  {31'd0, bus.signalOutput}, {31'd0, tab[t].sig});
         check("tab_busy", {31'd0, bus.busy},         {31'd0, tab[t].busy});
         check("tab_pend", 32'(bus.pendingCount),     32'(tab[t].pend));
         check("tab_ovf",  {31'd0, bus.overflow},     {31'd0, tab[t].ovf});
         step(1'b1, tab[t].pulse);
      end

      // Single pulse: 8 high, 4 gap, idle again in cycle 23.
      reset_seq();
      for (int t = 0; t < 30; t++) begin
         if (t == 10) check("s2_pre",  {31'd0, bus.signalOutput}, 32'd0);
         if (t == 11) check("s2_hi",   {31'd0, bus.signalOutput}, 32'd1);
         if (t == 18) check("s2_last", {31'd0, bus.signalOutput}, 32'd1);
         if (t == 19) check("s2_low",  {31'd0, bus.signalOutput}, 32'd0);
         if (t == 22) check("s2_busy", {31'd0, bus.busy},         32'd1);
         if (t == 23) check("s2_idle", {31'd0, bus.busy},         32'd0);
         step(1'b1, t == 10);
      end

      // Pulses in 10 and 12: second phase replays after the gap.
      reset_seq();
      for (int t = 0; t < 40; t++) begin
         if (t == 13) check("s3_pend",  32'(bus.pendingCount),     32'd1);
         if (t == 23) check("s3_hi2",   {31'd0, bus.signalOutput}, 32'd1);
         if (t == 23) check("s3_pend0", 32'(bus.pendingCount),     32'd0);
         if (t == 34) check("s3_busy",  {31'd0, bus.busy},         32'd1);
         if (t == 35) check("s3_idle",  {31'd0, bus.busy},         32'd0);
         step(1'b1, t == 10 || t == 12);
      end

      // Request in the last gap cycle with empty queue: no idle cycle.
      reset_seq();
      for (int t = 0; t < 40; t++) begin
         if (t == 22) check("s5_busy22", {31'd0, bus.busy},         32'd1);
         if (t == 23) check("s5_busy23", {31'd0, bus.busy},         32'd1);
         if (t == 23) check("s5_hi",     {31'd0, bus.signalOutput}, 32'd1);
         if (t == 23) check("s5_pend",   32'(bus.pendingCount),     32'd0);
         if (t == 31) check("s5_low",    {31'd0, bus.signalOutput}, 32'd0);
         step(1'b1, t == 10 || t == 22);
      end

      // Reset mid-phase discards current phase and queued requests.
      reset_seq();
      for (int t = 0; t < 50; t++) begin
         if (t == 14) check("s6_pend", 32'(bus.pendingCount), 32'd2);
         if (t == 15) begin
            check("s6_sig",  {31'd0, bus.signalOutput}, 32'd0);
            check("s6_busy", {31'd0, bus.busy},         32'd0);
            check("s6_pend0", 32'(bus.pendingCount),    32'd0);
         end
         if (t == 30) check("s6_noreplay", {31'd0, bus.busy}, 32'd0);
         step(t != 14, t == 10 || t == 11 || t == 12);
      end

      // Random traffic with varying request density and rare resets.
      reset_seq();
      for (int blk = 0; blk < 15; blk++) begin
         int dens;
         dens = $urandom_range(1, 12);
         for (int t = 0; t < 200; t++) begin
            p = ($urandom_range(0, 31) < dens);
            r = ($urandom_range(0, 299) != 0);
            step(r, p);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
